fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter sequencer for the IF stage of the hybrid ARM/MIPS pipeline. Owns the PC register.
//  Selects the next PC from four sources: sequential step, ALU branch redirect, hazard-unit stall, and instruction-memory wait.
//  Drives the imem request, IF/ID valid and IF/ID flush.
//  Replaces the bare PCsrc mux with a state machine that adds memory-wait, timeout and halt handling.
// PARAMETERS
//  PC_W      32  PC / target width in bits
//  RESET_PC  0   PC value loaded on reset
//  PC_STEP   4   sequential increment in bytes
//  MAX_WAIT  15  imem wait cycles allowed before the timeout halt (4-bit counter)
// PORTS
//  clk             in   1     rising-edge clock
//  rst             in   1     synchronous reset, active-high
//  stall_i         in   1     hazard unit: hold the PC
//  branch_taken_i  in   1     ALU branch/jump resolved as taken
//  branch_target_i in   PC_W  redirect target from the ALU
//  halt_i          in   1     stop fetching; only rst leaves the halt
//  imem_ready_i    in   1     imem returns the word for pc_o this cycle
//  pc_o            out  PC_W  current fetch address (registered)
//  imem_req_o      out  1     fetch request
//  inst_valid_o    out  1     IF/ID may capture the instruction
//  flush_o         out  1     kill the wrong-path IF/ID entry (registered, one-cycle pulse)
//  misalign_o      out  1     sticky: a target had bits[1:0] != 0
//  timeout_o       out  1     sticky: MAX_WAIT was exceeded
// BEHAVIOUR
//  Reset: while rst is high, on each edge:
//   - pc_o=RESET_PC, state=IDLE, wait_cnt=0
//   - flush_o, misalign_o and timeout_o cleared to 0
//  Combinational outputs while rst is high: imem_req_o=0, inst_valid_o=0.
//  rst mid-operation wins over every other input.
//  States are IDLE, FETCH, WAIT and HALTED.
//   - IDLE goes to FETCH unconditionally after 1 cycle.
//  imem_req_o = 1 only in the FETCH and WAIT states.
//  inst_valid_o = (state is FETCH or WAIT) & imem_ready_i & ~stall_i & ~branch_taken_i. It is combinational.
//  Per-edge priority in FETCH/WAIT, highest first:
//   1. branch_taken_i:
//      - pc_o <= branch_target_i & ~3
//      - flush_o <= 1 for exactly 1 cycle
//      - misalign_o set if target[1:0] != 0
//      - state <= FETCH, wait_cnt <= 0
//   2. halt_i: state <= HALTED, pc_o held.
//   3. stall_i: pc_o and state held; wait_cnt not incremented.
//   4. imem_ready_i: pc_o <= pc_o + PC_STEP (wraps modulo 2^PC_W); state <= FETCH; wait_cnt <= 0.
//   5. Otherwise (not ready): state <= WAIT, wait_cnt++.
//      - When wait_cnt == MAX_WAIT and the memory is still not ready: state <= HALTED, timeout_o <= 1.
//  HALTED: imem_req_o=0. branch_taken_i, stall_i and imem_ready_i are ignored. Exit only via rst.
//  Latency:
//   - redirect: the target appears on pc_o 1 cycle after branch_taken_i is sampled.
//   - sequential: 1 cycle per ready beat.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds two output ports, each 16-bit saturating (stick at 0xFFFF), cleared by rst:
//   - stall_cnt_o: counts cycles spent stalled or in WAIT
//   - redirect_cnt_o: counts taken redirects
//  FETCH_PERF_EN undefined: both ports and their counters are absent. All other behaviour is identical.
// STRUCTURE
//  fetch_pkg holds:
//   - typedef enum logic [1:0] fetch_state_t {IDLE, FETCH, WAIT, HALTED}
//   - localparams PC_ALIGN_MASK and PERF_CNT_W=16
//  One sub-module, fetch_next_pc: purely combinational next-PC mux and alignment. Instantiated once.
//  The FSM, wait counter and sticky flags live in fetch_sequencer.
// TESTING
//  1. rst for 2 cycles, then imem_ready_i=1 for 4 cycles -> pc_o 0 (IDLE), then 0,4,8,12; inst_valid_o high in FETCH.
//  2. At pc=4, branch_taken_i=1 with target=5 for 1 cycle -> pc_o=4 next cycle, flush_o pulses once, misalign_o=1; then sequential to 8.
//  3. stall_i and branch_taken_i (target=0x40) asserted together -> pc_o=0x40 and flush_o=1: the branch wins over the stall.
//  4. imem_ready_i=0 for 3 cycles at pc=8 -> pc_o holds 8 in WAIT with inst_valid_o=0; on ready -> pc_o=12.
//  5. imem_ready_i=0 for 16+ cycles -> HALTED, timeout_o=1, imem_req_o=0; later branches ignored; rst clears all.
//  6. pc=0xFFFF_FFFC with ready -> pc_o wraps to 0. With FETCH_PERF_EN: 3 redirects give redirect_cnt_o=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
// Optional build macro used by the slice: FETCH_PERF_EN (adds performance counters).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  // Low PC bits that must be zero for a word-aligned fetch address.
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;
  localparam int         PERF_CNT_W    = 16;

  function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
    return (&v) ? v : v + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: redirect (word-aligned target), sequential step, or hold.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int              PC_W    = 32,
  parameter logic [PC_W-1:0] PC_STEP = 4
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] branch_target,
  input  logic            redirect,
  input  logic            advance,
  output logic [PC_W-1:0] next_pc,
  output logic            target_misaligned
);

  logic [PC_W-1:0] align_mask;

  assign align_mask        = ~{{(PC_W-2){1'b0}}, PC_ALIGN_MASK};
  assign target_misaligned = |(branch_target[1:0] & PC_ALIGN_MASK);

  // Addition is modulo 2^PC_W, so the top of the address space wraps to zero.
  always_comb begin
    next_pc = pc;
    if (redirect) begin
      next_pc = branch_target & align_mask;
    end else if (advance) begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage PC sequencer: owns the PC, handles redirects, stalls, imem waits, timeout and halt.
// Define FETCH_PERF_EN to add saturating stall/redirect counters and their output ports.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] PC_STEP  = 4,
  parameter logic [3:0]      MAX_WAIT = 4'd15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_taken_i,
  input  logic [PC_W-1:0]       branch_target_i,
  input  logic                  halt_i,
  input  logic                  imem_ready_i,
  output logic [PC_W-1:0]       pc_o,
  output logic                  imem_req_o,
  output logic                  inst_valid_o,
  output logic                  flush_o,
  output logic                  misalign_o,
  output logic                  timeout_o
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt_o,
  output logic [PERF_CNT_W-1:0] redirect_cnt_o
`endif
);

  fetch_state_t    state_reg;
  logic [3:0]      wait_cnt_reg;
  logic [PC_W-1:0] pc_reg;
  logic            flush_reg;
  logic            misalign_reg;
  logic            timeout_reg;

  logic            active;
  logic [PC_W-1:0] pc_next;
  logic            target_misaligned;

  assign active = ~rst & ((state_reg == FETCH) | (state_reg == WAIT));

  fetch_next_pc #(
    .PC_W    (PC_W),
    .PC_STEP (PC_STEP)
  ) u_next_pc (
    .pc                (pc_reg),
    .branch_target     (branch_target_i),
    .redirect          (branch_taken_i),
    .advance           (imem_ready_i & ~stall_i & ~halt_i),
    .next_pc           (pc_next),
    .target_misaligned (target_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      pc_reg       <= RESET_PC;
      flush_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      flush_reg <= 1'b0;
      case (state_reg)
        IDLE: state_reg <= FETCH;
        FETCH, WAIT: begin
          if (branch_taken_i) begin
            pc_reg       <= pc_next;
            flush_reg    <= 1'b1;
            misalign_reg <= misalign_reg | target_misaligned;
            state_reg    <= FETCH;
            wait_cnt_reg <= 4'd0;
          end else if (halt_i) begin
            state_reg <= HALTED;
          end else if (stall_i) begin
            state_reg <= state_reg;
          end else if (imem_ready_i) begin
            pc_reg       <= pc_next;
            state_reg    <= FETCH;
            wait_cnt_reg <= 4'd0;
          end else if (wait_cnt_reg == MAX_WAIT) begin
            state_reg   <= HALTED;
            timeout_reg <= 1'b1;
          end else begin
            state_reg    <= WAIT;
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        HALTED: state_reg <= HALTED;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pc_o         = pc_reg;
  assign flush_o      = flush_reg;
  assign misalign_o   = misalign_reg;
  assign timeout_o    = timeout_reg;
  assign imem_req_o   = active;
  assign inst_valid_o = active & imem_ready_i & ~stall_i & ~branch_taken_i;

`ifdef FETCH_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_reg;
  logic [PERF_CNT_W-1:0] redirect_cnt_reg;

  // A stall cycle is either a memory wait or a hazard hold that actually kept the PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg    <= '0;
      redirect_cnt_reg <= '0;
    end else begin
      if ((state_reg == WAIT) | (active & stall_i & ~branch_taken_i & ~halt_i)) begin
        stall_cnt_reg <= sat_inc(stall_cnt_reg);
      end
      if (active & branch_taken_i) begin
        redirect_cnt_reg <= sat_inc(redirect_cnt_reg);
      end
    end
  end

  assign stall_cnt_o    = stall_cnt_reg;
  assign redirect_cnt_o = redirect_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, timeout corner, randomized model compare.
module tb_fetch_sequencer;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic        imem_ready_i;
  logic [31:0] pc_o;
  logic        imem_req_o;
  logic        inst_valid_o;
  logic        flush_o;
  logic        misalign_o;
  logic        timeout_o;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] redirect_cnt_o;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .imem_ready_i    (imem_ready_i),
    .pc_o            (pc_o),
    .imem_req_o      (imem_req_o),
    .inst_valid_o    (inst_valid_o),
    .flush_o         (flush_o),
    .misalign_o      (misalign_o),
    .timeout_o       (timeout_o)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt_o     (stall_cnt_o),
    .redirect_cnt_o  (redirect_cnt_o)
`endif
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic drive(input bit r, input bit s, input bit b, input logic [31:0] t,
                       input bit h, input bit y);
    rst = r; stall_i = s; branch_taken_i = b; branch_target_i = t; halt_i = h; imem_ready_i = y;
  endtask

  typedef struct {
    bit          rst, stall, br;
    logic [31:0] tgt;
    bit          halt, rdy;
    bit          e_req, e_valid;
    logic [31:0] e_pc;
    bit          e_flush, e_mis, e_to;
  } vec_t;

  vec_t vecs[20];

  // Reference model: whether fetching has started/stopped, and the run of consecutive misses.
  logic [31:0] m_pc;
  bit          m_run, m_halted, m_flush, m_mis, m_to;
  int          m_misses, m_redirects, m_stalls;

  task automatic model_edge();
    bit act;
    act = !rst && m_run && !m_halted;
    if (act && (m_misses > 0 || (stall_i && !branch_taken_i && !halt_i))) m_stalls++;
    m_flush = 1'b0;
    if (rst) begin
      m_pc = 32'h0; m_run = 0; m_halted = 0; m_mis = 0; m_to = 0;
      m_misses = 0; m_redirects = 0; m_stalls = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (!m_halted) begin
      if (branch_taken_i) begin
        m_pc = {branch_target_i[31:2], 2'b00};
        m_flush = 1'b1;
        if (branch_target_i[1:0] != 2'b00) m_mis = 1'b1;
        m_misses = 0;
        m_redirects++;
      end else if (halt_i) begin
        m_halted = 1;
      end else if (stall_i) begin
        m_pc = m_pc;
      end else if (imem_ready_i) begin
        m_pc = m_pc + 32'd4;
        m_misses = 0;
      end else if (m_misses == 15) begin
        m_halted = 1; m_to = 1;
      end else begin
        m_misses++;
      end
    end
  endtask

  task automatic rand_cycle(input int rdy_pct, input bit force_rst);
    bit          r, s, b, h, y, e_req;
    logic [31:0] t;
    r = force_rst || ($urandom_range(0, 59) == 0);
    s = ($urandom_range(0, 99) < 20);
    b = ($urandom_range(0, 99) < 12);
    h = ($urandom_range(0, 79) == 0);
    y = ($urandom_range(0, 99) < rdy_pct);
    t = $urandom;
    drive(r, s, b, t, h, y);
    #4;
    e_req = !r && m_run && !m_halted;
    chk("rnd_req", 32'(imem_req_o), 32'(e_req));
    chk("rnd_valid", 32'(inst_valid_o), 32'(e_req && y && !s && !b));
    @(posedge clk);
    model_edge();
    #1;
    chk("rnd_pc", pc_o, m_pc);
    chk("rnd_flush", 32'(flush_o), 32'(m_flush));
    chk("rnd_mis", 32'(misalign_o), 32'(m_mis));
    chk("rnd_to", 32'(timeout_o), 32'(m_to));
  endtask

  initial begin
    vecs[0]  = '{H,L,L,32'h0,L,L,        L,L,32'h0,L,L,L};
    vecs[1]  = '{H,L,L,32'h0,L,L,        L,L,32'h0,L,L,L};
    vecs[2]  = '{L,L,L,32'h0,L,H,        L,L,32'h0,L,L,L};
    vecs[3]  = '{L,L,L,32'h0,L,H,        H,H,32'h4,L,L,L};
    vecs[4]  = '{L,L,L,32'h0,L,H,        H,H,32'h8,L,L,L};
    vecs[5]  = '{L,L,L,32'h0,L,H,        H,H,32'hC,L,L,L};
    vecs[6]  = '{L,L,H,32'h5,L,H,        H,L,32'h4,H,H,L};
    vecs[7]  = '{L,L,L,32'h0,L,H,        H,H,32'h8,L,H,L};
    vecs[8]  = '{L,H,H,32'h40,L,L,       H,L,32'h40,H,H,L};
    vecs[9]  = '{L,H,L,32'h0,L,H,        H,L,32'h40,L,H,L};
    vecs[10] = '{L,L,H,32'h8,L,L,        H,L,32'h8,H,H,L};
    vecs[11] = '{L,L,L,32'h0,L,L,        H,L,32'h8,L,H,L};
    vecs[12] = '{L,L,L,32'h0,L,L,        H,L,32'h8,L,H,L};
    vecs[13] = '{L,L,L,32'h0,L,L,        H,L,32'h8,L,H,L};
    vecs[14] = '{L,L,L,32'h0,L,H,        H,H,32'hC,L,H,L};
    vecs[15] = '{L,L,H,32'hFFFF_FFFC,L,L,H,L,32'hFFFF_FFFC,H,H,L};
    vecs[16] = '{L,L,L,32'h0,L,H,        H,H,32'h0,L,H,L};
    vecs[17] = '{L,L,L,32'h0,H,H,        H,H,32'h0,L,H,L};
    vecs[18] = '{L,L,H,32'h80,L,H,       L,L,32'h0,L,H,L};
    vecs[19] = '{H,L,L,32'h0,L,L,        L,L,32'h0,L,L,L};

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].halt, vecs[i].rdy);
      #4;
      chk("vec_req", 32'(imem_req_o), 32'(vecs[i].e_req));
      chk("vec_valid", 32'(inst_valid_o), 32'(vecs[i].e_valid));
      @(posedge clk); #1;
      chk("vec_pc", pc_o, vecs[i].e_pc);
      chk("vec_flush", 32'(flush_o), 32'(vecs[i].e_flush));
      chk("vec_mis", 32'(misalign_o), 32'(vecs[i].e_mis));
      chk("vec_to", 32'(timeout_o), 32'(vecs[i].e_to));
      $display("vec %0d: pc=%h req=%b valid=%b flush=%b mis=%b to=%b",
               i, pc_o, imem_req_o, inst_valid_o, flush_o, misalign_o, timeout_o);
    end

    // Wait-limit boundary: 15 misses then ready survives; 16 misses times out.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    chk("wait15_req", 32'(imem_req_o), 32'd1);
    chk("wait15_pc", pc_o, 32'h0);
    imem_ready_i = 1'b1;
    #4;
    chk("wait15_valid", 32'(inst_valid_o), 32'd1);
    @(posedge clk); #1;
    chk("wait15_pc_step", pc_o, 32'h4);
    chk("wait15_to", 32'(timeout_o), 32'd0);
    imem_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_last_req", 32'(imem_req_o), 32'd1);
    chk("wait_last_to", 32'(timeout_o), 32'd0);
    @(posedge clk); #1;
    chk("timeout_flag", 32'(timeout_o), 32'd1);
    chk("timeout_req", 32'(imem_req_o), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1);
    #4;
    chk("halted_valid", 32'(inst_valid_o), 32'd0);
    @(posedge clk); #1;
    chk("halted_pc", pc_o, 32'h4);
    chk("halted_flush", 32'(flush_o), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst_clr_to", 32'(timeout_o), 32'd0);
    chk("rst_clr_pc", pc_o, 32'h0);
    $display("timeout sequence done: pc=%h to=%b", pc_o, timeout_o);

    // Randomized phase with varying memory readiness, checked against the model.
    rand_cycle(80, 1'b1);
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 120; i++) begin
        rand_cycle((blk == 2) ? 8 : (blk == 1 ? 50 : 85), 1'b0);
      end
      $display("random block %0d done: pc=%h to=%b mis=%b", blk, pc_o, timeout_o, misalign_o);
    end
`ifdef FETCH_PERF_EN
    chk("perf_redirects", 32'(redirect_cnt_o), 32'(m_redirects));
    chk("perf_stalls", 32'(stall_cnt_o), 32'(m_stalls));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
